// File: rtl/axil_to_reg_responder.sv
// axil_to_reg_responder
//   AXI-Lite slave that converts each read or write transaction into a single
//   register-interface request and returns the completion as an AXI-Lite B or R
//   response. Only one transaction is in flight at a time. AW and W are
//   buffered independently, so they can arrive in any order. B and R are held
//   until the master accepts them.
//
//   Optional feature: define AXIL_REG_TIMEOUT_EN to abort a reg request with
//   SLVERR once it has waited TIMEOUT_CYCLES cycles without reg_ready_i.
//
// Ports
//   clk_i, rst_i                  clock; synchronous active-high reset
//   s_aw_* / s_w_* / s_b_*        AXI-Lite write address / data / response
//   s_ar_* / s_r_*                AXI-Lite read address / data+response
//   reg_addr_o, reg_wdata_o,      reg request fields, held constant while
//   reg_wstrb_o, reg_write_o,     reg_valid_o is high
//   reg_valid_o
//   reg_rdata_i, reg_error_i,     reg completion, sampled only while
//   reg_ready_i                   reg_valid_o is high
module axil_to_reg_responder #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH    = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0] s_aw_addr_i,
  input  logic [2:0]                s_aw_prot_i,
  input  logic                      s_aw_valid_i,
  output logic                      s_aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] s_w_data_i,
  input  logic [STRB_WIDTH-1:0]     s_w_strb_i,
  input  logic                      s_w_valid_i,
  output logic                      s_w_ready_o,
  output logic [1:0]                s_b_resp_o,
  output logic                      s_b_valid_o,
  input  logic                      s_b_ready_i,
  input  logic [AXI_ADDR_WIDTH-1:0] s_ar_addr_i,
  input  logic [2:0]                s_ar_prot_i,
  input  logic                      s_ar_valid_i,
  output logic                      s_ar_ready_o,
  output logic [AXI_DATA_WIDTH-1:0] s_r_data_o,
  output logic [1:0]                s_r_resp_o,
  output logic                      s_r_valid_o,
  input  logic                      s_r_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] reg_addr_o,
  output logic [AXI_DATA_WIDTH-1:0] reg_wdata_o,
  output logic [STRB_WIDTH-1:0]     reg_wstrb_o,
  output logic                      reg_write_o,
  output logic                      reg_valid_o,
  input  logic [AXI_DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                      reg_error_i,
  input  logic                      reg_ready_i
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, REG_WR, REG_RD, WR_RSP, RD_RSP} state_t;

  state_t                    state;
  logic                      aw_full, w_full, ar_full;
  logic                      aw_rdy, w_rdy, ar_rdy;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0]     w_strb_q;
  logic                      rr_last_wr;

  logic aw_hs, w_hs, ar_hs;
  logic aw_avail, w_avail, ar_avail;
  logic wr_go, rd_go;
  logic reg_done, reg_tmo;
  logic wr_fin, rd_fin;
  logic aw_full_n, w_full_n, ar_full_n;

  // Protection bits carry no meaning for this peripheral.
  logic unused_prot;
  assign unused_prot = ^{s_aw_prot_i, s_ar_prot_i};

  assign s_aw_ready_o = aw_rdy;
  assign s_w_ready_o  = w_rdy;
  assign s_ar_ready_o = ar_rdy;

  assign aw_hs = s_aw_valid_i & aw_rdy;
  assign w_hs  = s_w_valid_i  & w_rdy;
  assign ar_hs = s_ar_valid_i & ar_rdy;

  // A handshake happening this cycle counts as available. This lets the reg
  // request start the cycle right after the last handshake, bypassing the
  // buffer.
  assign aw_avail = aw_full | aw_hs;
  assign w_avail  = w_full  | w_hs;
  assign ar_avail = ar_full | ar_hs;

  // Round-robin: when both directions are ready, the one not served last wins.
  assign wr_go = (state == IDLE) & aw_avail & w_avail & (~ar_avail | ~rr_last_wr);
  assign rd_go = (state == IDLE) & ar_avail & ~wr_go;

  assign reg_done = reg_valid_o & reg_ready_i;

`ifdef AXIL_REG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts cycles spent with reg_valid_o high. The count is 0 in the entry
  // cycle, so expiry happens after TIMEOUT_CYCLES further cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i || !reg_valid_o)
      tmo_cnt <= '0;
    else if (tmo_cnt != CNT_W'(TIMEOUT_CYCLES))
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  // A completion in the same cycle as expiry takes priority.
  assign reg_tmo = reg_valid_o & ~reg_ready_i & (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign reg_tmo = 1'b0;
`endif

  assign wr_fin = (state == REG_WR) & (reg_done | reg_tmo);
  assign rd_fin = (state == REG_RD) & (reg_done | reg_tmo);

  // Buffers are released when the reg side finishes, so the next AW/W/AR can
  // be accepted while the response phase is still running.
  assign aw_full_n = aw_avail & ~wr_fin;
  assign w_full_n  = w_avail  & ~wr_fin;
  assign ar_full_n = ar_avail & ~rd_fin;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      ar_full     <= 1'b0;
      aw_rdy      <= 1'b0;
      w_rdy       <= 1'b0;
      ar_rdy      <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      rr_last_wr  <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wstrb_o <= '0;
      reg_write_o <= 1'b0;
      reg_valid_o <= 1'b0;
      s_b_valid_o <= 1'b0;
      s_b_resp_o  <= RESP_OKAY;
      s_r_valid_o <= 1'b0;
      s_r_data_o  <= '0;
      s_r_resp_o  <= RESP_OKAY;
    end else begin
      aw_full <= aw_full_n;
      w_full  <= w_full_n;
      ar_full <= ar_full_n;
      aw_rdy  <= ~aw_full_n;
      w_rdy   <= ~w_full_n;
      ar_rdy  <= ~ar_full_n;

      if (aw_hs) aw_addr_q <= s_aw_addr_i;
      if (ar_hs) ar_addr_q <= s_ar_addr_i;
      if (w_hs) begin
        w_data_q <= s_w_data_i;
        w_strb_q <= s_w_strb_i;
      end

      case (state)
        IDLE: begin
          if (wr_go) begin
            state       <= REG_WR;
            reg_valid_o <= 1'b1;
            reg_write_o <= 1'b1;
            reg_addr_o  <= aw_full ? aw_addr_q : s_aw_addr_i;
            reg_wdata_o <= w_full ? w_data_q : s_w_data_i;
            reg_wstrb_o <= w_full ? w_strb_q : s_w_strb_i;
            rr_last_wr  <= 1'b1;
          end else if (rd_go) begin
            state       <= REG_RD;
            reg_valid_o <= 1'b1;
            reg_write_o <= 1'b0;
            reg_addr_o  <= ar_full ? ar_addr_q : s_ar_addr_i;
            reg_wdata_o <= '0;
            reg_wstrb_o <= '0;
            rr_last_wr  <= 1'b0;
          end
        end
        REG_WR: begin
          if (wr_fin) begin
            state       <= WR_RSP;
            reg_valid_o <= 1'b0;
            reg_write_o <= 1'b0;
            s_b_valid_o <= 1'b1;
            s_b_resp_o  <= (reg_done && !reg_error_i) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        REG_RD: begin
          if (rd_fin) begin
            state       <= RD_RSP;
            reg_valid_o <= 1'b0;
            s_r_valid_o <= 1'b1;
            s_r_data_o  <= reg_done ? reg_rdata_i : '0;
            s_r_resp_o  <= (reg_done && !reg_error_i) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        WR_RSP: begin
          if (s_b_ready_i) begin
            state       <= IDLE;
            s_b_valid_o <= 1'b0;
            s_b_resp_o  <= RESP_OKAY;
          end
        end
        RD_RSP: begin
          if (s_r_ready_i) begin
            state       <= IDLE;
            s_r_valid_o <= 1'b0;
            s_r_data_o  <= '0;
            s_r_resp_o  <= RESP_OKAY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_to_reg_responder.sv
// Testbench for axil_to_reg_responder. Stimulus pushes the expected reg
// requests and B/R responses into queues. A forked monitor pops and compares
// those queues whenever the DUT presents a request or a response. A forked
// responder models the reg-side peripheral with a programmable latency.
module tb_axil_to_reg_responder;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rrsp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] s_aw_addr_i = '0;
  logic [2:0]  s_aw_prot_i = '0;
  logic        s_aw_valid_i = 1'b0;
  logic        s_aw_ready_o;
  logic [31:0] s_w_data_i = '0;
  logic [3:0]  s_w_strb_i = '0;
  logic        s_w_valid_i = 1'b0;
  logic        s_w_ready_o;
  logic [1:0]  s_b_resp_o;
  logic        s_b_valid_o;
  logic        s_b_ready_i = 1'b1;
  logic [31:0] s_ar_addr_i = '0;
  logic [2:0]  s_ar_prot_i = '0;
  logic        s_ar_valid_i = 1'b0;
  logic        s_ar_ready_o;
  logic [31:0] s_r_data_o;
  logic [1:0]  s_r_resp_o;
  logic        s_r_valid_o;
  logic        s_r_ready_i = 1'b1;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_write_o;
  logic        reg_valid_o;
  logic [31:0] reg_rdata_i = '0;
  logic        reg_error_i = 1'b0;
  logic        reg_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  int          rsp_delay = 0;
  logic [31:0] rsp_data  = '0;
  logic        rsp_err   = 1'b0;

  req_t        exp_req[$];
  logic [1:0]  exp_b[$];
  rrsp_t       exp_r[$];

  axil_to_reg_responder #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_aw_addr_i(s_aw_addr_i), .s_aw_prot_i(s_aw_prot_i),
    .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o),
    .s_w_data_i(s_w_data_i), .s_w_strb_i(s_w_strb_i),
    .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o),
    .s_b_resp_o(s_b_resp_o), .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i),
    .s_ar_addr_i(s_ar_addr_i), .s_ar_prot_i(s_ar_prot_i),
    .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
    .s_r_data_o(s_r_data_o), .s_r_resp_o(s_r_resp_o),
    .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_write_o(reg_write_o), .reg_valid_o(reg_valid_o),
    .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i), .reg_ready_i(reg_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reg-side peripheral: raises ready rsp_delay cycles after valid rises.
  task automatic responder();
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (reg_valid_o) begin
        if (cnt == rsp_delay) begin
          reg_ready_i = 1'b1;
          reg_rdata_i = rsp_data;
          reg_error_i = rsp_err;
        end else begin
          reg_ready_i = 1'b0;
          reg_rdata_i = '0;
          reg_error_i = 1'b0;
        end
        cnt++;
      end else begin
        cnt = 0;
        reg_ready_i = 1'b0;
        reg_rdata_i = '0;
        reg_error_i = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic        prev_rv = 1'b0;
    logic        r_hold  = 1'b0;
    logic [31:0] r_last_d = '0;
    logic [1:0]  r_last_r = '0;
    req_t        rq;
    rrsp_t       rr;
    logic [1:0]  bx;
    forever begin
      @(negedge clk);
      if (reg_valid_o && !prev_rv) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual addr=%h required none", reg_addr_o);
        end else begin
          rq = exp_req.pop_front();
          chk("req_addr", reg_addr_o, rq.addr);
          chk("req_write", 32'(reg_write_o), 32'(rq.wr));
          if (rq.wr) begin
            chk("req_wdata", reg_wdata_o, rq.wdata);
            chk("req_wstrb", 32'(reg_wstrb_o), 32'(rq.strb));
          end
        end
      end
      prev_rv = reg_valid_o;

      if (s_b_valid_o && s_b_ready_i) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_b actual resp=%h required none", s_b_resp_o);
        end else begin
          bx = exp_b.pop_front();
          chk("b_resp", 32'(s_b_resp_o), 32'(bx));
        end
      end

      if (s_r_valid_o) begin
        if (r_hold) begin
          chk("r_data_stable", s_r_data_o, r_last_d);
          chk("r_resp_stable", 32'(s_r_resp_o), 32'(r_last_r));
        end
        if (s_r_ready_i) begin
          r_hold = 1'b0;
          if (exp_r.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_r actual data=%h required none", s_r_data_o);
          end else begin
            rr = exp_r.pop_front();
            chk("r_data", s_r_data_o, rr.data);
            chk("r_resp", 32'(s_r_resp_o), 32'(rr.resp));
          end
        end else begin
          r_hold   = 1'b1;
          r_last_d = s_r_data_o;
          r_last_r = s_r_resp_o;
        end
      end else begin
        r_hold = 1'b0;
      end
    end
  endtask

  initial begin
    logic seen;
    fork
      monitor();
      responder();
      begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset: all outputs low while rst_i is high, readies rise afterwards.
    cyc(2);
    @(negedge clk);
    chk("rst_aw_ready", 32'(s_aw_ready_o), 32'd0);
    chk("rst_w_ready",  32'(s_w_ready_o),  32'd0);
    chk("rst_ar_ready", 32'(s_ar_ready_o), 32'd0);
    chk("rst_b_valid",  32'(s_b_valid_o),  32'd0);
    chk("rst_r_valid",  32'(s_r_valid_o),  32'd0);
    chk("rst_reg_valid", 32'(reg_valid_o), 32'd0);
    cyc(1);
    rst_i = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("post_rst_aw_ready", 32'(s_aw_ready_o), 32'd1);
    chk("post_rst_w_ready",  32'(s_w_ready_o),  32'd1);
    chk("post_rst_ar_ready", 32'(s_ar_ready_o), 32'd1);

    // AW and W in the same cycle; reg_ready two cycles after valid.
    cyc(1);
    rsp_delay = 2; rsp_err = 1'b0;
    exp_req.push_back('{addr: 32'h10, wr: 1'b1, wdata: 32'hDEADBEEF, strb: 4'hF});
    exp_b.push_back(2'b00);
    s_aw_addr_i = 32'h10; s_aw_valid_i = 1'b1;
    s_w_data_i = 32'hDEADBEEF; s_w_strb_i = 4'hF; s_w_valid_i = 1'b1;
    cyc(1);
    s_aw_valid_i = 1'b0; s_w_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_reg_valid_lat", 32'(reg_valid_o), 32'd1);
    chk("t1_reg_write", 32'(reg_write_o), 32'd1);
    cyc(2);
    @(negedge clk);
    chk("t1_b_not_early", 32'(s_b_valid_o), 32'd0);
    chk("t1_reg_valid_held", 32'(reg_valid_o), 32'd1);
    cyc(1);
    @(negedge clk);
    chk("t1_b_valid_lat", 32'(s_b_valid_o), 32'd1);
    chk("t1_reg_valid_drop", 32'(reg_valid_o), 32'd0);
    cyc(2);

    // W three cycles ahead of AW: no request until AW arrives.
    rsp_delay = 0;
    s_w_data_i = 32'h1234; s_w_strb_i = 4'h3; s_w_valid_i = 1'b1;
    cyc(1);
    s_w_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_w_ready_low", 32'(s_w_ready_o), 32'd0);
    chk("t2_no_req", 32'(reg_valid_o), 32'd0);
    cyc(1);
    @(negedge clk);
    chk("t2_no_req2", 32'(reg_valid_o), 32'd0);
    cyc(1);
    exp_req.push_back('{addr: 32'h20, wr: 1'b1, wdata: 32'h1234, strb: 4'h3});
    exp_b.push_back(2'b00);
    s_aw_addr_i = 32'h20; s_aw_valid_i = 1'b1;
    cyc(1);
    s_aw_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_reg_valid", 32'(reg_valid_o), 32'd1);
    cyc(4);

    // Read with error; R held while r_ready is low for four cycles.
    rsp_delay = 1; rsp_data = 32'hCAFE0001; rsp_err = 1'b1;
    s_r_ready_i = 1'b0;
    exp_req.push_back('{addr: 32'h40, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    exp_r.push_back('{data: 32'hCAFE0001, resp: 2'b10});
    s_ar_addr_i = 32'h40; s_ar_valid_i = 1'b1;
    cyc(1);
    s_ar_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = s_r_valid_o;
    end
    chk("t3_r_valid_seen", 32'(seen), 32'd1);
    chk("t3_r_data", s_r_data_o, 32'hCAFE0001);
    chk("t3_r_resp", 32'(s_r_resp_o), 32'h2);
    cyc(4);
    s_r_ready_i = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("t3_r_valid_drop", 32'(s_r_valid_o), 32'd0);
    cyc(2);

    // Arbitration: AW+W+AR together, a second AW+W queued behind.
    // Expected order: write, read, write.
    rsp_delay = 0; rsp_data = 32'h5A5A0000; rsp_err = 1'b0;
    exp_req.push_back('{addr: 32'h100, wr: 1'b1, wdata: 32'hA1, strb: 4'hF});
    exp_req.push_back('{addr: 32'h200, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    exp_req.push_back('{addr: 32'h104, wr: 1'b1, wdata: 32'hA2, strb: 4'h0});
    exp_b.push_back(2'b00);
    exp_b.push_back(2'b00);
    exp_r.push_back('{data: 32'h5A5A0000, resp: 2'b00});
    s_aw_addr_i = 32'h100; s_aw_valid_i = 1'b1;
    s_w_data_i = 32'hA1; s_w_strb_i = 4'hF; s_w_valid_i = 1'b1;
    s_ar_addr_i = 32'h200; s_ar_valid_i = 1'b1;
    cyc(1);
    s_ar_valid_i = 1'b0;
    s_aw_addr_i = 32'h104; s_w_data_i = 32'hA2; s_w_strb_i = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = s_aw_ready_o && s_w_ready_o;
    end
    chk("t4_aw2_accept", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    s_aw_valid_i = 1'b0; s_w_valid_i = 1'b0;
    cyc(12);

    // Reset while a read waits on the reg side.
    rsp_delay = 1000;
    exp_req.push_back('{addr: 32'h80, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    s_ar_addr_i = 32'h80; s_ar_valid_i = 1'b1;
    cyc(1);
    s_ar_valid_i = 1'b0;
    cyc(2);
    rst_i = 1'b1;
    @(negedge clk);
    chk("t5_reg_valid_wait", 32'(reg_valid_o), 32'd1);
    cyc(1);
    @(negedge clk);
    chk("t5_reg_valid_rst", 32'(reg_valid_o), 32'd0);
    chk("t5_ar_ready_rst", 32'(s_ar_ready_o), 32'd0);
    cyc(1);
    rst_i = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("t5_ar_ready_back", 32'(s_ar_ready_o), 32'd1);
    chk("t5_aw_ready_back", 32'(s_aw_ready_o), 32'd1);
    cyc(5);
    @(negedge clk);
    chk("t5_no_r", 32'(s_r_valid_o), 32'd0);
    cyc(1);

`ifdef AXIL_REG_TIMEOUT_EN
    // Peripheral never answers: SLVERR nine cycles after valid rises.
    rsp_delay = 1000;
    exp_req.push_back('{addr: 32'h30, wr: 1'b1, wdata: 32'h55, strb: 4'h1});
    exp_b.push_back(2'b10);
    s_aw_addr_i = 32'h30; s_aw_valid_i = 1'b1;
    s_w_data_i = 32'h55; s_w_strb_i = 4'h1; s_w_valid_i = 1'b1;
    cyc(1);
    s_aw_valid_i = 1'b0; s_w_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_reg_valid", 32'(reg_valid_o), 32'd1);
    cyc(8);
    @(negedge clk);
    chk("t6_still_waiting", 32'(reg_valid_o), 32'd1);
    chk("t6_b_not_early", 32'(s_b_valid_o), 32'd0);
    cyc(1);
    @(negedge clk);
    chk("t6_b_timeout", 32'(s_b_valid_o), 32'd1);
    chk("t6_reg_valid_drop", 32'(reg_valid_o), 32'd0);
    cyc(3);
`else
    // No timeout: a slow peripheral is waited on well past TIMEOUT_CYCLES.
    rsp_delay = 25;
    exp_req.push_back('{addr: 32'h30, wr: 1'b1, wdata: 32'h55, strb: 4'h1});
    exp_b.push_back(2'b00);
    s_aw_addr_i = 32'h30; s_aw_valid_i = 1'b1;
    s_w_data_i = 32'h55; s_w_strb_i = 4'h1; s_w_valid_i = 1'b1;
    cyc(1);
    s_aw_valid_i = 1'b0; s_w_valid_i = 1'b0;
    cyc(20);
    @(negedge clk);
    chk("t6_still_waiting", 32'(reg_valid_o), 32'd1);
    chk("t6_no_b", 32'(s_b_valid_o), 32'd0);
    cyc(10);
`endif

    chk("left_req", 32'(exp_req.size()), 32'd0);
    chk("left_b",   32'(exp_b.size()),   32'd0);
    chk("left_r",   32'(exp_r.size()),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
